// File: rtl/shift_timer_pkg.sv
// Shared types and constants for the shift/count timer sequencer.
// Ports: none (package only).
// Holds the controller state encoding, the start code and the delay width.
package shift_timer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S1       = 3'd1,
    S11      = 3'd2,
    S110     = 3'd3,
    SHIFT    = 3'd4,
    COUNT    = 3'd5,
    WAIT_ACK = 3'd6
  } st_e;

  localparam logic [3:0] START_CODE = 4'b1101;
  localparam int         DELAY_W    = 4;

endpackage

// File: rtl/shift_count_reg.sv
// 4-bit shift / count-down register: shifts data in MSB first, or decrements.
// Ports: clk, reset (sync clear), shift_ena, count_ena, data in; q out.
// Shift wins over count; with neither enable the value holds.
module shift_count_reg
  import shift_timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_ena,
  input  logic               count_ena,
  input  logic               data,
  output logic [DELAY_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (shift_ena) begin
      q <= {q[DELAY_W-2:0], data};
    end else if (count_ena) begin
      // The controller only asserts count_ena while q is non-zero, so this never wraps.
      q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/shift_timer_ctrl.sv
// Sequencer: finds start code 1101, shifts in a 4-bit delay, counts (delay+1)*TICKS cycles.
// Ports: clk, reset (sync, active-high), data, ack in; shift_ena, counting, done, count out.
// All outputs are Moore-decoded from registered state; ack is only honoured while done is high.
module shift_timer_ctrl
  import shift_timer_pkg::*;
#(
  parameter int TICKS = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  output logic               shift_ena,
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] count
);

  localparam int            TW        = $clog2(TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

  st_e               state, nxt;
  logic [1:0]        idx;
  logic [TW-1:0]     tick;
  logic [DELAY_W-1:0] q;
  logic              count_ena;
  logic              tick_last;

  assign tick_last = (tick == TICK_LAST);

  // State register plus the SHIFT bit index and COUNT tick counter.
  // Both counters sit at zero outside their own state, so entry needs no extra clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      tick  <= '0;
    end else begin
      state <= nxt;
      idx   <= (state == SHIFT) ? idx + 2'd1 : 2'd0;
      tick  <= (state == COUNT && !tick_last) ? tick + 1'b1 : '0;
    end
  end

  // Next-state logic. S11 staying in S11 on a 1 is what lets 11101 still match.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = (data == START_CODE[3]) ? S1    : IDLE;
      S1:       nxt = (data == START_CODE[2]) ? S11   : IDLE;
      S11:      nxt = (data == START_CODE[1]) ? S110  : S11;
      S110:     nxt = (data == START_CODE[0]) ? SHIFT : IDLE;
      SHIFT:    nxt = (idx == 2'd3) ? COUNT : SHIFT;
      COUNT:    nxt = (tick_last && q == '0) ? WAIT_ACK : COUNT;
      WAIT_ACK: nxt = ack ? IDLE : WAIT_ACK;
      default:  nxt = IDLE;
    endcase
  end

  // Output decode. count_ena is gated by q != 0 so the final step goes to WAIT_ACK
  // instead of decrementing.
  always_comb begin
    shift_ena = 1'b0;
    counting  = 1'b0;
    done      = 1'b0;
    count_ena = 1'b0;
    case (state)
      SHIFT:    shift_ena = 1'b1;
      COUNT: begin
        counting  = 1'b1;
        count_ena = tick_last && (q != '0);
      end
      WAIT_ACK: done = 1'b1;
      default: ;
    endcase
  end

  assign count = q;

  shift_count_reg u_reg (
    .clk       (clk),
    .reset     (reset),
    .shift_ena (shift_ena),
    .count_ena (count_ena),
    .data      (data),
    .q         (q)
  );

endmodule

// File: tb/tb_shift_timer_ctrl.sv
module tb_shift_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       data;
  logic       ack;
  logic       shift_ena;
  logic       counting;
  logic       done;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_timer_ctrl #(.TICKS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .ack       (ack),
    .shift_ena (shift_ena),
    .counting  (counting),
    .done      (done),
    .count     (count)
  );

  // Inputs change at the falling edge; outputs are read at the falling edge,
  // i.e. they reflect the rising edge just before.
  task automatic send_bit(input logic b);
    data = b;
    @(negedge clk);
  endtask

  task automatic send_code(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) send_bit(c[i]);
  endtask

  // Shifts a delay in, reporting how many of those cycles had shift_ena high.
  task automatic shift_delay(input logic [3:0] d, output int hi);
    hi = 0;
    for (int i = 3; i >= 0; i--) begin
      if (shift_ena) hi++;
      send_bit(d[i]);
    end
    data = 1'b0;
  endtask

  task automatic measure_count(output int n);
    n = 0;
    while (counting && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; data = 1'b0; ack = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({shift_ena, counting, done, count} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got se=%b cnt=%b done=%b count=%0d want all 0",
               shift_ena, counting, done, count);
    end
  endtask

  task automatic test_basic();
    int hi, n, bad;
    send_code(4'b1101);
    shift_delay(4'b1010, hi);
    checks++;
    if (hi !== 4) begin errors++; $display("FAIL basic_shift_cycles got %0d want 4", hi); end
    checks++;
    if (count !== 4'd10) begin errors++; $display("FAIL basic_loaded got %0d want 10", count); end
    n = 0; bad = 0;
    while (counting && n < 300) begin
      if (count !== 4'(10 - n / 4)) bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 44) begin errors++; $display("FAIL basic_count_len got %0d want 44", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL basic_count_steps got %0d bad cycles want 0", bad); end
    checks++;
    if (done !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL basic_done got done=%b count=%0d want 1/0", done, count);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done_hold got %b want 1", done); end
    pulse_ack();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_drop got %b want 0", done); end
  endtask

  task automatic test_overlap();
    int hi, n;
    send_bit(1'b1);
    send_code(4'b1101);
    checks++;
    if (shift_ena !== 1'b1) begin errors++; $display("FAIL overlap_detect got %b want 1", shift_ena); end
    shift_delay(4'b0000, hi);
    measure_count(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL overlap_count_len got %0d want 4", n); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL overlap_done got %b want 1", done); end
    pulse_ack();
  endtask

  task automatic test_ignore_inputs();
    int hi, n, se_seen;
    logic [3:0] pat;
    pat = 4'b1101;
    send_code(4'b1101);
    shift_delay(4'b0010, hi);
    n = 0; se_seen = 0;
    while (counting && n < 300) begin
      if (shift_ena) se_seen++;
      data = pat[3 - (n % 4)];
      ack  = 1'b1;
      n++;
      @(negedge clk);
    end
    data = 1'b0;
    checks++;
    if (n !== 12) begin errors++; $display("FAIL ignore_count_len got %0d want 12", n); end
    checks++;
    if (se_seen !== 0) begin errors++; $display("FAIL ignore_no_restart got %0d shift cycles want 0", se_seen); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ignore_done got %b want 1", done); end
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL ignore_done_clear got %b want 0", done); end
  endtask

  task automatic test_mid_reset();
    int hi, n, se_seen;
    send_code(4'b1101);
    shift_delay(4'b0101, hi);
    for (int i = 0; i < 9; i++) @(negedge clk);
    checks++;
    if (counting !== 1'b1 || count !== 4'd3) begin
      errors++; $display("FAIL midrst_pre got counting=%b count=%0d want 1/3", counting, count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({shift_ena, counting, done, count} !== 7'b0) begin
      errors++; $display("FAIL midrst_clear got se=%b cnt=%b done=%b count=%0d want all 0",
                         shift_ena, counting, done, count);
    end
    se_seen = 0;
    send_bit(1'b1); if (shift_ena) se_seen++;
    send_bit(1'b0); if (shift_ena) se_seen++;
    send_bit(1'b1); if (shift_ena) se_seen++;
    send_bit(1'b1); if (shift_ena) se_seen++;
    checks++;
    if (se_seen !== 0) begin errors++; $display("FAIL midrst_no_start got %0d want 0", se_seen); end
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (shift_ena !== 1'b1) begin errors++; $display("FAIL midrst_fresh_start got %b want 1", shift_ena); end
    shift_delay(4'b0000, hi);
    measure_count(n);
    pulse_ack();
  endtask

  task automatic test_near_miss();
    int hi, n, early;
    logic [7:0] s;
    s = 8'b1100_1101;
    early = 0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(s[i]);
      if (shift_ena) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL nearmiss_false got %0d want 0", early); end
    send_bit(s[0]);
    checks++;
    if (shift_ena !== 1'b1) begin errors++; $display("FAIL nearmiss_detect got %b want 1", shift_ena); end
    shift_delay(4'b0000, hi);
    measure_count(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL nearmiss_count_len got %0d want 4", n); end
    pulse_ack();
  endtask

  task automatic test_max_delay();
    int hi, n, both, wrap;
    logic [3:0] prev;
    send_code(4'b1101);
    shift_delay(4'b1111, hi);
    checks++;
    if (count !== 4'd15) begin errors++; $display("FAIL max_loaded got %0d want 15", count); end
    n = 0; both = 0; wrap = 0; prev = count;
    while (counting && n < 300) begin
      if (shift_ena && dut.count_ena) both++;
      if (count > prev) wrap++;
      prev = count;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL max_count_len got %0d want 64", n); end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL max_enables_overlap got %0d want 0", both); end
    checks++;
    if (wrap !== 0 || count !== 4'd0) begin
      errors++; $display("FAIL max_no_wrap got wraps=%0d count=%0d want 0/0", wrap, count);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL max_done got %b want 1", done); end
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_ignore_inputs();
    test_mid_reset();
    test_near_miss();
    test_max_delay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
